// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder: shifts out a programmable frame, captures the master's frame.
module spi_responder #(
  parameter int FRAME_BYTES = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     btn_reset,
  input  logic                     SS,
  input  logic                     SCLK,
  input  logic                     MOSI,
  output logic                     MISO,
  input  logic [8*FRAME_BYTES-1:0] tx_data,
  output logic [8*FRAME_BYTES-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int FRAME_BITS = 8 * FRAME_BYTES;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                   ss_hist, sclk_hist, mosi_hist;
  logic                   ss_rise, ss_fall, sclk_rise, sclk_fall;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   tx_shift;
  logic [FRAME_BITS-1:0]   rx_shift;

  // Edge pulses are registered so MOSI's history flop lines up with the SCLK edge it belongs to.
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_hist   <= 1'b0;
      sclk_hist <= 1'b0;
      mosi_hist <= 1'b0;
      ss_rise   <= 1'b0;
      ss_fall   <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_hist   <= ss_sync[SYNC_STAGES-1];
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      mosi_hist <= mosi_sync[SYNC_STAGES-1];
      ss_rise   <= ss_sync[SYNC_STAGES-1] & ~ss_hist;
      ss_fall   <= ~ss_sync[SYNC_STAGES-1] & ss_hist;
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_hist;
      sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_hist;
    end
  end

  always_ff @(posedge clk) begin
    if (btn_reset) begin
      state     <= WAIT_IDLE;
      MISO      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        // Only join the bus once SS is seen idle, never mid-frame.
        WAIT_IDLE: begin
          busy <= 1'b0;
          MISO <= 1'b0;
          if (ss_hist) state <= IDLE;
        end
        IDLE: begin
          busy <= 1'b0;
          MISO <= 1'b0;
          if (ss_fall) begin
            tx_shift <= tx_data;
            MISO     <= tx_data[FRAME_BITS-1];
            bit_cnt  <= '0;
            rx_shift <= '0;
            busy     <= 1'b1;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            MISO  <= 1'b0;
            if (bit_cnt == CNT_FULL) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            if (bit_cnt < CNT_FULL) rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_hist};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt >= CNT_LAST) MISO <= 1'b0;
          end else if (sclk_fall) begin
            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
            MISO     <= (bit_cnt >= CNT_FULL) ? 1'b0 : tx_shift[FRAME_BITS-2];
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI mode-0 peripheral (responder) end of the parking meter's SPI link.
- It answers the meter's SS/SCLK/MOSI master and drives MISO with a programmable response frame.
- It captures the bytes the master sends.
- Used on-board and in benches as a stand-in Pmod sensor, so the meter's SPI master can be exercised without hardware.

Parameters:
- FRAME_BYTES, 5, number of bytes per SS-low frame; frame length = 8*FRAME_BYTES bits.
- SYNC_STAGES, 2, synchronizer flops on each of SS, SCLK and MOSI (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- btn_reset  input  1  synchronous, active-high reset.
- SS  input  1  slave select from master, active low, asynchronous to clk.
- SCLK  input  1  serial clock from master; idles low (mode 0).
- MOSI  input  1  serial data from master, MSB first.
- MISO  output  1  serial data to master, MSB first.
- tx_data  input  8*FRAME_BYTES  response frame; byte 0 is in the MSBs and is sent first.
- rx_data  output  8*FRAME_BYTES  last complete frame received; byte 0 in the MSBs.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- frame_err  output  1  one-cycle pulse at the end of a short or overlong frame.
- busy  output  1  high while a frame is in progress (state ACTIVE).

Behaviour:
- Reset values: MISO=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, state=WAIT_IDLE, bit counter=0.
- Input conditioning:
  - SS, SCLK and MOSI each pass through SYNC_STAGES flops, then one history flop for edge detection.
  - Edge detection occurs SYNC_STAGES+1 clk cycles after the pin changes.
  - Master requirement: SCLK high and SCLK low each last at least SYNC_STAGES+2 clk cycles.
- State machine:
  - WAIT_IDLE: entered on reset. Stays here until synced SS=1, then goes to IDLE. This prevents joining a frame already in progress.
  - IDLE: MISO=0, busy=0. On a synced SS falling edge:
    - latch tx_data into tx_shift;
    - MISO = tx_shift MSB, taking effect the cycle after the edge is detected;
    - bit_cnt=0, rx_shift=0;
    - go to ACTIVE.
  - ACTIVE: busy=1.
    - SCLK rising edge: rx_shift = {rx_shift, MOSI_sync}; bit_cnt increments, saturating at 8*FRAME_BYTES+1.
    - SCLK falling edge: tx_shift shifts left with zero fill; MISO = new MSB.
    - Once bit_cnt >= 8*FRAME_BYTES, MISO=0 and MOSI bits are no longer captured.
    - On a synced SS rising edge, go to IDLE:
      - bit_cnt == 8*FRAME_BYTES: rx_data <= rx_shift and rx_valid=1 for one cycle.
      - Otherwise (short frame, including zero bits, or overlong frame): frame_err=1 for one cycle and rx_data is unchanged.
- tx_data is sampled only at frame start; changes mid-frame do not affect the frame in progress.
- Simultaneous events: if an SS rising edge and an SCLK edge are detected in the same cycle, SS wins and the SCLK edge is ignored.
- rx_valid and frame_err are never high in the same cycle.
- Reset mid-frame: all outputs return to their reset values and the state goes to WAIT_IDLE. A partial frame produces no rx_valid and no frame_err.
- Latency: rx_valid rises SYNC_STAGES+2 clk cycles after the SS pin rises.

Test Plan:
- Reset: hold btn_reset high for 10 cycles with SS=1 and SCLK toggling.
  - Required: MISO=0, rx_valid=0, frame_err=0, busy=0 throughout.
- Full frame: tx_data=0xA53C0FF081; master sends 0x8001020304 with 40 SCLKs, SCLK period 16 clk.
  - Required: master samples 0xA5,0x3C,0x0F,0xF0,0x81.
  - Required: exactly one rx_valid pulse, 4 cycles after SS rises, with rx_data=0x8001020304; busy falls in the same cycle.
- Short frame: SS rises after 20 bits.
  - Required: one frame_err pulse, no rx_valid, rx_data keeps its previous value 0x8001020304.
- Overlong frame: 44 SCLKs.
  - Required: MISO=0 for bits 41-44, one frame_err pulse, no rx_valid, rx_data unchanged.
- Reset mid-frame: assert btn_reset at bit 12 while SS stays low.
  - Required: no response until SS goes high then low again.
  - Required: the next full 40-bit frame yields a correct rx_valid and MISO data.
- tx_data change: change tx_data to 0xFFFFFFFFFF at bit 8 of the frame.
  - Required: the current frame still returns its latched value.
  - Required: the next frame returns 0xFFFFFFFFFF.
